// File: rtl/uart_pkg.sv
// uart_pkg: parity codes, TX FSM states and width helpers shared by the UART blocks
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int baud_w(input int div);
    return $clog2(div);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and an occupancy count
module sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [addr_w(DEPTH):0] count
);
  localparam int AW = addr_w(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with configurable data/parity/stop bits
module uart_tx_fifo import uart_pkg::*; #(
  parameter int FREQ       = 50_000_000,
  parameter int BPS        = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic [DATA_BITS-1:0]        tx_data,
  output logic                        ready,
  output logic                        txd,
  output logic                        busy,
  output logic [addr_w(FIFO_DEPTH):0] fifo_count
);
  localparam int DIV = FREQ / BPS;
  localparam int BW  = baud_w(DIV);
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: FREQ/BPS must be at least 2");
  end
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic par_q, par_d, tick, pop, empty, full;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(valid), .pop(pop), .din(tx_data),
    .dout(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign ready = !full;
  assign busy  = state_q != IDLE || fifo_count != '0;
  assign tick  = baud_q == BW'(DIV - 1);
  assign pop   = state_q == IDLE && !empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = START;
      START:   if (tick) state_d = DATA;
      DATA:    if (tick && bit_q == 4'(DATA_BITS - 1)) state_d = PARITY != PAR_NONE ? PAR : STOP;
      PAR:     if (tick) state_d = STOP;
      STOP:    if (tick && bit_q == 4'(STOP_BITS - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Baud phase is held at zero while idle so each frame starts aligned to its own start bit.
  always_comb begin
    baud_d  = state_q == IDLE || tick ? '0 : baud_q + 1'b1;
    bit_d   = state_d != state_q ? '0 : tick ? bit_q + 1'b1 : bit_q;
    shift_d = pop ? head : state_q == DATA && tick ? shift_q >> 1 : shift_q;
    par_d   = pop ? (PARITY == PAR_EVEN ? ^head : ~^head) : par_q;
  end
  always_comb begin
    txd = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : state_q == PAR ? par_q : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed checks of framing, parity, stop bits, FIFO limits and reset abort
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic va = 1'b0, ve = 1'b0, vo = 1'b0, vf = 1'b0, vq = 1'b0;
  logic [7:0] d8 = '0;
  logic [4:0] d5 = '0;
  logic ra, re, ro, rf, rq;
  logic txa, txe, txo, txf, txq;
  logic ba, be, bo, bf, bq;
  logic [4:0] ca, ce, co, cf;
  logic [2:0] cq;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  uart_tx_fifo #(.FREQ(1000), .BPS(100)) u_a (
    .clk(clk), .rst(rst), .valid(va), .tx_data(d8), .ready(ra), .txd(txa), .busy(ba), .fifo_count(ca));
  uart_tx_fifo #(.FREQ(1000), .BPS(100), .PARITY(2)) u_e (
    .clk(clk), .rst(rst), .valid(ve), .tx_data(d8), .ready(re), .txd(txe), .busy(be), .fifo_count(ce));
  uart_tx_fifo #(.FREQ(1000), .BPS(100), .PARITY(1)) u_o (
    .clk(clk), .rst(rst), .valid(vo), .tx_data(d8), .ready(ro), .txd(txo), .busy(bo), .fifo_count(co));
  uart_tx_fifo #(.FREQ(1000), .BPS(100), .DATA_BITS(5), .STOP_BITS(2)) u_f (
    .clk(clk), .rst(rst), .valid(vf), .tx_data(d5), .ready(rf), .txd(txf), .busy(bf), .fifo_count(cf));
  uart_tx_fifo #(.FREQ(1000), .BPS(100), .FIFO_DEPTH(4)) u_q (
    .clk(clk), .rst(rst), .valid(vq), .tx_data(d8), .ready(rq), .txd(txq), .busy(bq), .fifo_count(cq));

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int n, input int slot);
    return slot == 0 ? 1'b0 : slot <= n ? d[slot-1] : 1'b1;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    vectors += 3;
    if ({txa, ra, ba} !== 3'b110) begin miscompares++; $display("FAIL reset_a txd/ready/busy got %b want 110", {txa, ra, ba}); end
    if (ca !== 5'd0) begin miscompares++; $display("FAIL reset_a count got %0d want 0", ca); end
    if ({txq, rq, bq, cq} !== 6'b110000) begin miscompares++; $display("FAIL reset_q got %b want 110000", {txq, rq, bq, cq}); end
    rst = 1'b0;
  endtask

  task automatic test_8n1;
    d8 = 8'hA5;
    va = 1'b1;
    tick();
    va = 1'b0;
    vectors++;
    if (ca !== 5'd1 || txa !== 1'b1) begin miscompares++; $display("FAIL 8n1_queued count=%0d txd=%b want 1 1", ca, txa); end
    tick();
    for (int off = 0; off < 100; off++) begin
      vectors += 2;
      if (txa !== frame_bit(8'hA5, 8, off / 10)) begin miscompares++; $display("FAIL 8n1_txd off=%0d got %b want %b", off, txa, frame_bit(8'hA5, 8, off / 10)); end
      if (ba !== 1'b1) begin miscompares++; $display("FAIL 8n1_busy off=%0d got %b want 1", off, ba); end
      tick();
    end
    vectors++;
    if ({ba, txa, ca} !== 7'b0100000) begin miscompares++; $display("FAIL 8n1_end busy/txd/count got %b want 0100000", {ba, txa, ca}); end
  endtask

  task automatic test_parity;
    logic exp_e, exp_o;
    d8 = 8'h07;
    ve = 1'b1;
    vo = 1'b1;
    tick();
    ve = 1'b0;
    vo = 1'b0;
    tick();
    for (int off = 0; off < 110; off++) begin
      exp_e = off / 10 == 9 ? 1'b1 : frame_bit(8'h07, 8, off / 10);
      exp_o = off / 10 == 9 ? 1'b0 : frame_bit(8'h07, 8, off / 10);
      vectors += 3;
      if (txe !== exp_e) begin miscompares++; $display("FAIL even_txd off=%0d got %b want %b", off, txe, exp_e); end
      if (txo !== exp_o) begin miscompares++; $display("FAIL odd_txd off=%0d got %b want %b", off, txo, exp_o); end
      if ({be, bo} !== 2'b11) begin miscompares++; $display("FAIL par_busy off=%0d got %b want 11", off, {be, bo}); end
      tick();
    end
    vectors++;
    if ({be, bo} !== 2'b00) begin miscompares++; $display("FAIL par_end busy got %b want 00", {be, bo}); end
  endtask

  task automatic test_5n2;
    d5 = 5'h1F;
    vf = 1'b1;
    tick();
    vf = 1'b0;
    tick();
    for (int off = 0; off < 80; off++) begin
      vectors += 2;
      if (txf !== frame_bit(8'h1F, 5, off / 10)) begin miscompares++; $display("FAIL 5n2_txd off=%0d got %b want %b", off, txf, frame_bit(8'h1F, 5, off / 10)); end
      if (bf !== 1'b1) begin miscompares++; $display("FAIL 5n2_busy off=%0d got %b want 1", off, bf); end
      tick();
    end
    vectors++;
    if ({bf, txf} !== 2'b01) begin miscompares++; $display("FAIL 5n2_end busy/txd got %b want 01", {bf, txf}); end
  endtask

  task automatic test_fifo_full;
    logic [7:0] dat [6] = '{8'h11, 8'h22, 8'h3C, 8'h5A, 8'h81, 8'hFF};
    int exp_cnt [6] = '{1, 1, 2, 3, 4, 4};
    logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_tx;
    int pos;
    do_reset();
    vq = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d8 = dat[i];
      tick();
      vectors += 2;
      if (cq !== 3'(exp_cnt[i])) begin miscompares++; $display("FAIL full_count write=%0d got %0d want %0d", i, cq, exp_cnt[i]); end
      if (rq !== exp_rdy[i]) begin miscompares++; $display("FAIL full_ready write=%0d got %b want %b", i, rq, exp_rdy[i]); end
    end
    vq = 1'b0;
    for (int off = 4; off < 505; off++) begin
      pos = off % 101;
      exp_tx = pos == 100 ? 1'b1 : frame_bit(dat[off / 101], 8, pos / 10);
      vectors += 2;
      if (txq !== exp_tx) begin miscompares++; $display("FAIL b2b_txd off=%0d got %b want %b", off, txq, exp_tx); end
      if (bq !== (off != 504)) begin miscompares++; $display("FAIL b2b_busy off=%0d got %b want %b", off, bq, off != 504); end
      tick();
    end
    vectors++;
    if ({bq, txq, cq} !== 5'b01000) begin miscompares++; $display("FAIL b2b_end busy/txd/count got %b want 01000", {bq, txq, cq}); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] dat [3] = '{8'hF0, 8'h33, 8'hCC};
    do_reset();
    vq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d8 = dat[i];
      tick();
    end
    vq = 1'b0;
    tick(42);
    vectors += 2;
    if (txq !== 1'b0) begin miscompares++; $display("FAIL abort_pre_txd got %b want 0", txq); end
    if (cq !== 3'd2) begin miscompares++; $display("FAIL abort_pre_count got %0d want 2", cq); end
    rst = 1'b1;
    tick();
    vectors++;
    if ({txq, cq, bq, rq} !== 6'b100001) begin miscompares++; $display("FAIL abort_reset txd/count/busy/ready got %b want 100001", {txq, cq, bq, rq}); end
    rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      vectors++;
      if ({txq, bq} !== 2'b10) begin miscompares++; $display("FAIL abort_quiet cyc=%0d txd/busy got %b want 10", i, {txq, bq}); end
    end
  endtask

  task automatic test_full_pop;
    do_reset();
    vq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d8 = 8'h40 + 8'(i);
      tick();
    end
    vq = 1'b0;
    tick(97);
    vectors++;
    if ({cq, rq, txq} !== 5'b10001) begin miscompares++; $display("FAIL fullpop_pre count/ready/txd got %b want 10001", {cq, rq, txq}); end
    d8 = 8'h99;
    vq = 1'b1;
    tick();
    vectors++;
    if ({cq, rq} !== 4'b0111) begin miscompares++; $display("FAIL fullpop_after count/ready got %b want 0111", {cq, rq}); end
    tick();
    vq = 1'b0;
    vectors++;
    if ({cq, rq} !== 4'b1000) begin miscompares++; $display("FAIL fullpop_refill count/ready got %b want 1000", {cq, rq}); end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_5n2();
    test_fifo_full();
    test_reset_mid();
    test_full_pop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
